// File: rtl/sha256d_nonce_scheduler.sv
// Nonce search sequencer for a single-block SHA-256 core: two core passes per nonce
// (double SHA-256), digest compared against a target until hit, range end, abort or timeout.
module sha256d_nonce_scheduler #(
    parameter int NONCE_WORD = 3,
    parameter int WDOG_CYC   = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic         abort,
    input  logic [511:0] tmpl,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         exhausted,
    output logic         err,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         core_reset,
    output logic         core_start,
    output logic [511:0] core_data_in,
    input  logic [255:0] core_data_out,
    input  logic         core_done
);

    localparam int WD_W = $clog2(WDOG_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST1, S_START1, S_WAIT1, S_CAP1, S_RST2, S_START2, S_WAIT2, S_CMP
    } state_t;

    state_t         state_q, state_d;
    logic [511:0]   tmpl_q, tmpl_d;
    logic [255:0]   target_q, target_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    nonce_end_q, nonce_end_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [511:0]   data_in_q, data_in_d;
    logic           done_q, done_d;
    logic           found_q, found_d;
    logic           exhausted_q, exhausted_d;
    logic           err_q, err_d;
    logic [31:0]    found_nonce_q, found_nonce_d;
    logic [255:0]   found_hash_q, found_hash_d;

    logic hit, last_nonce, wd_expired;

    function automatic logic [511:0] with_nonce(input logic [511:0] blk, input logic [31:0] n);
        logic [511:0] b;
        b = blk;
        b[32*NONCE_WORD +: 32] = n;
        return b;
    endfunction

    // Second pass hashes the 32-byte first digest, padded as a one-block 256-bit message.
    function automatic logic [511:0] second_block(input logic [255:0] d);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[32*i +: 32] = d[255-32*i -: 32];
        end
        b[32*8 +: 32]  = 32'h8000_0000;
        b[32*15 +: 32] = 32'h0000_0100;
        return b;
    endfunction

    assign hit        = core_data_out < target_q;
    assign last_nonce = nonce_q == nonce_end_q;
    assign wd_expired = wd_q == WD_W'(WDOG_CYC - 1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (go) state_d = S_RST1;
                S_RST1:   state_d = S_START1;
                S_START1: state_d = S_WAIT1;
                S_WAIT1:  if (core_done) state_d = S_CAP1;
                          else if (wd_expired) state_d = S_IDLE;
                S_CAP1:   state_d = S_RST2;
                S_RST2:   state_d = S_START2;
                S_START2: state_d = S_WAIT2;
                S_WAIT2:  if (core_done) state_d = S_CMP;
                          else if (wd_expired) state_d = S_IDLE;
                S_CMP:    state_d = (hit || last_nonce) ? S_IDLE : S_RST1;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = state_q != S_IDLE;
        core_reset = state_q inside {S_IDLE, S_RST1, S_RST2};
        core_start = state_q inside {S_START1, S_START2};
    end

    always_comb begin
        tmpl_d        = tmpl_q;
        target_d      = target_q;
        nonce_d       = nonce_q;
        nonce_end_d   = nonce_end_q;
        wd_d          = wd_q;
        data_in_d     = data_in_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        err_d         = err_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        // Every exit to IDLE (hit, range end, abort, timeout) produces exactly one done.
        done_d        = (state_q != S_IDLE) && (state_d == S_IDLE);
        case (state_q)
            S_IDLE: if (go) begin
                tmpl_d      = tmpl;
                target_d    = target;
                nonce_d     = nonce_start;
                nonce_end_d = nonce_end;
                found_d     = 1'b0;
                exhausted_d = 1'b0;
                err_d       = 1'b0;
            end
            S_RST1:             data_in_d = with_nonce(tmpl_q, nonce_q);
            S_START1, S_START2: wd_d = WD_W'(1);
            S_WAIT1, S_WAIT2: begin
                if (!core_done) wd_d = wd_q + WD_W'(1);
                if (state_d == S_IDLE && !abort) err_d = 1'b1;
            end
            S_CAP1:             data_in_d = second_block(core_data_out);
            S_CMP: if (!abort) begin
                if (hit) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                    found_hash_d  = core_data_out;
                end else if (last_nonce) begin
                    exhausted_d = 1'b1;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            err_q         <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            data_in_q     <= '0;
        end else begin
            done_q        <= done_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            err_q         <= err_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            data_in_q     <= data_in_d;
        end
    end

    always_ff @(posedge clk) begin
        tmpl_q      <= tmpl_d;
        target_q    <= target_d;
        nonce_q     <= nonce_d;
        nonce_end_q <= nonce_end_d;
        wd_q        <= wd_d;
    end

    assign done         = done_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign err          = err_q;
    assign found_nonce  = found_nonce_q;
    assign found_hash   = found_hash_q;
    assign core_data_in = data_in_q;

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Bench for sha256d_nonce_scheduler: behavioural SHA-256 core plus a search-level reference model.
module tb_sha256d_nonce_scheduler;
    localparam int NW   = 0;
    localparam int WDOG = 96;

    logic         clk = 1'b0;
    logic         reset, go, abort;
    logic [511:0] tmpl;
    logic [31:0]  nonce_start, nonce_end;
    logic [255:0] target;
    logic         busy, done, found, exhausted, err;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         core_reset, core_start;
    logic [511:0] core_data_in;
    logic [255:0] core_data_out = '0;
    logic         core_done = 1'b0;

    always #5 clk = ~clk;

    sha256d_nonce_scheduler #(.NONCE_WORD(NW), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort), .tmpl(tmpl),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .busy(busy), .done(done), .found(found), .exhausted(exhausted), .err(err),
        .found_nonce(found_nonce), .found_hash(found_hash),
        .core_reset(core_reset), .core_start(core_start), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_done(core_done)
    );

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression from the standard IV; block word i is blk[32i+31:32i].
    function automatic logic [255:0] sha_blk(input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] v [0:7];
        logic [31:0] s0, s1, ch, mj, t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int j = 0; j < 8; j++) v[j] = IV[255-32*j -: 32];
        for (int i = 0; i < 64; i++) begin
            s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
            ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
            t1 = v[7] + s1 + ch + K[i] + w[i];
            s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
            mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t2 = s0 + mj;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) r[255-32*j -: 32] = IV[255-32*j -: 32] + v[j];
        return r;
    endfunction

    function automatic logic [511:0] put_nonce(input logic [511:0] t, input logic [31:0] n);
        logic [511:0] b;
        b = t;
        b[32*NW +: 32] = n;
        return b;
    endfunction

    function automatic logic [511:0] pad_digest(input logic [255:0] d);
        logic [255:0] rev;
        rev = {<<32{d}};
        return {32'h0000_0100, 192'h0, 32'h8000_0000, rev};
    endfunction

    function automatic logic [255:0] dsha(input logic [511:0] t, input logic [31:0] n);
        return sha_blk(pad_digest(sha_blk(put_nonce(t, n))));
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural core: result appears the cycle after core_done (garbage during it).
    bit           core_mute = 1'b0;
    bit           lat_fix   = 1'b0;
    logic [511:0] c_blk;
    int           c_cnt;
    bit           c_run = 1'b0, c_pend = 1'b0;
    int           stable_err = 0;
    logic [511:0] started_q[$];

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_reset) begin
            c_run  <= 1'b0;
            c_pend <= 1'b0;
        end else begin
            if (c_pend) begin
                core_data_out <= sha_blk(c_blk);
                c_pend        <= 1'b0;
                if (core_data_in !== c_blk) stable_err <= stable_err + 1;
            end
            if (core_start) begin
                c_blk <= core_data_in;
                c_run <= 1'b1;
                c_cnt <= lat_fix ? 20 : int'($urandom_range(1, 12));
                started_q.push_back(core_data_in);
            end else if (c_run) begin
                if (core_data_in !== c_blk) stable_err <= stable_err + 1;
                if (c_cnt == 0) begin
                    if (!core_mute) begin
                        core_done     <= 1'b1;
                        c_pend        <= 1'b1;
                        c_run         <= 1'b0;
                        core_data_out <= {8{32'hDEADBEEF}};
                    end
                end else begin
                    c_cnt <= c_cnt - 1;
                end
            end
        end
    end

    int n_chk = 0, n_pass = 0;
    logic [511:0] exp_q[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Search-level reference: expected core block sequence and final outcome.
    task automatic model(input logic [511:0] t, input logic [31:0] ns, input logic [31:0] ne,
                         input logic [255:0] tg, output bit f, output bit ex,
                         output logic [31:0] fn, output logic [255:0] fh);
        logic [31:0]  n;
        logic [511:0] b1, b2;
        logic [255:0] d2;
        exp_q.delete();
        f = 1'b0; ex = 1'b0; fn = '0; fh = '0;
        n = ns;
        for (int k = 0; k < 64; k++) begin
            b1 = put_nonce(t, n);
            b2 = pad_digest(sha_blk(b1));
            d2 = sha_blk(b2);
            exp_q.push_back(b1);
            exp_q.push_back(b2);
            if (d2 < tg) begin f = 1'b1; fn = n; fh = d2; break; end
            if (n == ne) begin ex = 1'b1; break; end
            n = n + 32'd1;
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, " busy"}, busy, 0);
        chk({p, " done"}, done, 0);
        chk({p, " found"}, found, 0);
        chk({p, " exhausted"}, exhausted, 0);
        chk({p, " err"}, err, 0);
        chk({p, " core_start"}, core_start, 0);
        chk({p, " core_reset"}, core_reset, 1);
        chk({p, " found_nonce"}, found_nonce, 0);
        chk({p, " found_hash"}, found_hash, 0);
        chk({p, " core_data_in"}, core_data_in, 0);
    endtask

    // Launch a search, then scramble the inputs to prove they were latched.
    task automatic pulse_go(input string nm, input logic [511:0] t, input logic [31:0] ns,
                            input logic [31:0] ne, input logic [255:0] tg);
        tmpl = t; nonce_start = ns; nonce_end = ne; target = tg;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk({nm, " busy_after_go"}, busy, 1);
        tmpl = rand512(); nonce_start = $urandom; nonce_end = $urandom;
        target = {8{$urandom}};
    endtask

    task automatic search(input string nm, input logic [511:0] t, input logic [31:0] ns,
                          input logic [31:0] ne, input logic [255:0] tg, input bit rego);
        bit f, ex, seen;
        logic [31:0] fn;
        logic [255:0] fh;
        int q0, se0, extra;
        model(t, ns, ne, tg, f, ex, fn, fh);
        q0 = started_q.size();
        se0 = stable_err;
        pulse_go(nm, t, ns, ne, tg);
        seen = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (done) begin seen = 1'b1; break; end
            go = rego && (c == 7);
            tick();
        end
        go = 1'b0;
        chk({nm, " done_seen"}, seen, 1);
        chk({nm, " busy_at_done"}, busy, 0);
        chk({nm, " found"}, found, f);
        chk({nm, " exhausted"}, exhausted, ex);
        chk({nm, " err"}, err, 0);
        if (f) begin
            chk({nm, " found_nonce"}, found_nonce, fn);
            chk({nm, " found_hash"}, found_hash, fh);
        end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done) extra++;
        end
        chk({nm, " extra_done"}, extra, 0);
        chk({nm, " found_held"}, found, f);
        chk({nm, " core_starts"}, started_q.size() - q0, exp_q.size());
        for (int i = 0; i < exp_q.size() && q0 + i < started_q.size(); i++)
            chk($sformatf("%s blk%0d", nm, i), started_q[q0+i], exp_q[i]);
        chk({nm, " data_in_stable"}, stable_err - se0, 0);
    endtask

    initial begin
        logic [511:0] t;
        logic [255:0] d9;
        int s, e, q0;
        bit ok;

        reset = 1'b1; go = 1'b0; abort = 1'b0;
        tmpl = '0; nonce_start = '0; nonce_end = '0; target = '0;
        tick(); tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort done", done, 0);

        t = '0;
        t[31:0]    = 32'h61626380;
        t[511:480] = 32'h00000018;
        search("abc", t, 32'h61626380, 32'h61626380, '1, 1'b0);
        chk("abc known_hash", found_hash,
            256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358);

        search("exhaust", rand512(), 32'd5, 32'd7, '0, 1'b1);

        t  = rand512();
        d9 = dsha(t, 32'd9);
        search("multi", t, 32'd0, 32'd15, d9 + 256'd1, 1'b1);

        search("wrap", rand512(), 32'hFFFF_FFFE, 32'd1, '0, 1'b1);

        // Abort while the second pass is in flight.
        lat_fix = 1'b1;
        q0 = started_q.size();
        pulse_go("abort", rand512(), 32'd0, 32'd3, '0);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (started_q.size() >= q0 + 2) begin ok = 1'b1; break; end
            tick();
        end
        chk("abort reached_wait2", ok, 1);
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort done", done, 1);
        chk("abort busy", busy, 0);
        chk("abort flags", {found, exhausted, err}, 3'b000);
        tick();
        chk("abort done_pulse", done, 0);
        lat_fix = 1'b0;

        // Core that never answers.
        core_mute = 1'b1;
        pulse_go("wdog", rand512(), 32'd0, 32'd3, '0);
        s = -1; e = -1;
        for (int c = 0; c < 300; c++) begin
            if (core_start && s < 0) s = c;
            if (err) begin e = c; break; end
            tick();
        end
        chk("wdog latency", e - s, WDOG);
        chk("wdog done", done, 1);
        chk("wdog busy", busy, 0);
        chk("wdog found_exh", {found, exhausted}, 2'b00);
        core_mute = 1'b0;
        tick();

        search("pre_reset", rand512(), 32'd100, 32'd103, '1, 1'b0);

        // Reset during the first capture cycle, then a normal search.
        pulse_go("rst", rand512(), 32'd0, 32'd3, '0);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (core_done) begin ok = 1'b1; break; end
            tick();
        end
        chk("rst reached_done", ok, 1);
        tick();
        reset = 1'b1;
        tick();
        chk_reset_vals("midreset");
        reset = 1'b0;
        tick();
        search("post_reset", rand512(), 32'd20, 32'd27, 256'd1 << 254, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha256d_nonce_scheduler.md
# sha256d_nonce_scheduler

Sequencing controller for the single-block `sha256_module` core in the mining datapath. Inserts a 32-bit nonce into a configured 512-bit block template and runs a double SHA-256 per nonce (two core passes, with a core reset before each pass). Compares each final digest against a 256-bit target and iterates nonces until a hit, range exhaustion or abort. Sits between the host register interface and the single hash core instance.

## Interface
- `NONCE_WORD`, default 3: index (0-15) of the template word replaced by the nonce.
- `WDOG_CYC`, default 96: maximum cycles allowed from `core_start` to `core_done`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `go` in 1: one-cycle pulse that launches a search. Ignored unless `busy`=0.
- `abort` in 1: terminates the search. Returns to IDLE next cycle.
- `tmpl` in 512: block template. Word i = `tmpl[32i+31:32i]` (core word order).
- `nonce_start`, `nonce_end` in 32 each: inclusive search range.
- `target` in 256: hit when digest < target, unsigned, H0 in bits [255:224].
- `busy` out 1: high from the cycle after an accepted `go` until return to IDLE.
- `done` out 1: one-cycle pulse when the search ends (hit, exhausted, abort or error).
- `found` out 1: sticky hit flag. Cleared on `go`.
- `exhausted` out 1: sticky range-end flag. Cleared on `go`.
- `err` out 1: sticky watchdog flag. Cleared on `go`.
- `found_nonce` out 32: nonce of the hit.
- `found_hash` out 256: double digest of the hit.
- `core_reset` out 1: drives the core `reset`.
- `core_start` out 1: drives the core `start`.
- `core_data_in` out 512: drives the core `data_in`.
- `core_data_out` in 256: core digest. Valid the cycle after `core_done`.
- `core_done` in 1: core done pulse.

## Operation
- Reset values:
  - `busy`, `done`, `found`, `exhausted`, `err`, `core_start` = 0.
  - `core_reset` = 1.
  - `found_nonce`, `found_hash`, `core_data_in` = 0.
- Inputs `tmpl`, `nonce_start`, `nonce_end` and `target` are latched on an accepted `go`. Later changes have no effect until the next `go`.
- States: IDLE, RST1, START1, WAIT1, CAP1, RST2, START2, WAIT2, CMP.
- IDLE:
  - `core_reset`=1.
  - On `go`: nonce ← `nonce_start`, clear the sticky flags, go to RST1.
- RST1 / RST2: `core_reset`=1 for exactly one cycle, then START1 / START2.
- START1:
  - `core_start`=1 for one cycle.
  - `core_data_in` = latched template with word `NONCE_WORD` = nonce.
  - Watchdog counter cleared.
- WAIT1: wait for `core_done`, then go to CAP1.
- CAP1:
  - Latch `core_data_out` as d1.
  - Build the second block:
    - words 0-7 = d1 (word i = `d1[255-32i -: 32]`);
    - word 8 = 32'h80000000;
    - words 9-14 = 0;
    - word 15 = 32'h00000100.
  - Go to RST2.
- START2 / WAIT2: same behaviour as pass 1.
- CMP, entered the cycle after `core_done` in WAIT2 (digest d2 valid). Priority order:
  1. `abort`;
  2. d2 < target → `found`=1, `found_nonce`=nonce, `found_hash`=d2, `done`, IDLE;
  3. nonce == `nonce_end` → `exhausted`=1, `done`, IDLE;
  4. otherwise nonce+1 (mod 2^32), RST1.
- `core_data_in` is held stable from START through the cycle in which `core_done` is seen.
- Watchdog:
  - Counts in WAIT1/WAIT2.
  - Reaching `WDOG_CYC` without `core_done` → `err`=1, `done`, IDLE.
- `abort` in any non-IDLE state → IDLE next cycle, `done` pulse, no flag change. `abort` in IDLE is ignored.
- `nonce_start` > `nonce_end`: the search wraps through 2^32-1 → 0 until it reaches `nonce_end`.
- `nonce_start` == `nonce_end`: exactly one attempt.
- `reset` mid-search: immediate return to reset values. Any in-flight core result is discarded.

## Timing
- `go` → RST1 in the next cycle. `busy` rises in that same cycle.
- Per pass: RST(1) + START(1) + WAIT (until `core_done`) + 1 capture cycle.
- No idle cycles between consecutive nonces beyond the RST/START states.
- `done` is registered and coincident with the IDLE entry cycle. `busy` falls in that same cycle.
- Result outputs are stable when `done` is high and hold until the next `go` or `reset`.

## Test plan
- "abc" vector:
  - Setup: `NONCE_WORD`=0, template = padded "abc" (word0 = 32'h61626380, word15 = 32'h18), `nonce_start`=`nonce_end`=32'h61626380, target = all-ones.
  - Expect: `found`=1 and `found_hash` = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358.
- Exhaustion:
  - Setup: target = 0, range 5..7.
  - Expect: three attempts, `exhausted`=1, `found`=0, exactly one `done` pulse.
- Multi-nonce hit:
  - Setup: random template, range 0..15, target = the reference-model digest for nonce 9, plus 1.
  - Expect: `found_nonce`=9, unless a lower nonce also hits per the model.
- Wrap-around:
  - Setup: range 32'hFFFFFFFE..1, target = 0.
  - Expect: the core sees nonces FFFFFFFE, FFFFFFFF, 0, 1, then `exhausted`.
- Abort and watchdog:
  - Abort: `abort` asserted mid-WAIT2 → IDLE next cycle, `done`=1, no sticky flags set.
  - Watchdog: stubbed core never asserts `core_done` → `err`=1 exactly `WDOG_CYC` cycles after START1.
- Reset mid-search:
  - Stimulus: `reset` asserted in CAP1.
  - Expect: all outputs at reset values the next cycle, and a following `go` runs correctly.
